// File: rtl/ram_reader_checker.sv
// Read-back checker for the 256x8 SPRAM: streams reads over an address window and
// compares every returned byte against an incrementing pattern, reporting the first failure.
module ram_reader_checker #(
   parameter int STARTUP_CYCLES = 100,
   parameter int READ_LATENCY   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] first_addr,
   input  logic [8:0] count,
   input  logic [7:0] first_word,
   input  logic [7:0] ram_q,
   output logic [7:0] ram_addr,
   output logic [7:0] ram_d,
   output logic       ram_enb,
   output logic       ram_oeb,
   output logic       ram_web,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [8:0] err_count,
   output logic [7:0] first_err_addr,
   output logic [7:0] first_err_data,
   output logic [7:0] x
);

   typedef enum logic [2:0] {ST_STARTUP, ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

   localparam int SCW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
   localparam int DCW = $clog2(READ_LATENCY + 1);

   state_t           state;
   logic [SCW-1:0]   su_cnt;
   logic [7:0]       base_addr;
   logic [7:0]       base_word;
   logic [8:0]       run_cnt;
   logic [8:0]       idx;
   logic [DCW-1:0]   drain_cnt;
   logic             issue_vld;
   logic [7:0]       issue_exp;

   // Tags follow each issued address until its data is on ram_q.
   logic             pv [READ_LATENCY];
   logic [7:0]       pa [READ_LATENCY];
   logic [7:0]       pe [READ_LATENCY];

   logic             cmp_vld;
   logic             mismatch;
   logic [8:0]       err_next;
   logic [8:0]       cnt_in;

   assign ram_d   = 8'h00;
   assign ram_web = 1'b1;

   assign cmp_vld  = pv[READ_LATENCY-1];
   assign mismatch = cmp_vld && (ram_q != pe[READ_LATENCY-1]);
   assign err_next = err_count + {8'b0, mismatch && (err_count != 9'd256)};
   assign cnt_in   = (count > 9'd256) ? 9'd256 : count;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_STARTUP;
         su_cnt         <= '0;
         base_addr      <= 8'h00;
         base_word      <= 8'h00;
         run_cnt        <= 9'd0;
         idx            <= 9'd0;
         drain_cnt      <= '0;
         issue_vld      <= 1'b0;
         issue_exp      <= 8'h00;
         ram_addr       <= 8'h00;
         ram_enb        <= 1'b1;
         ram_oeb        <= 1'b1;
         ready          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= 9'd0;
         first_err_addr <= 8'h00;
         first_err_data <= 8'h00;
         x              <= 8'h00;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pv[i] <= 1'b0;
            pa[i] <= 8'h00;
            pe[i] <= 8'h00;
         end
      end else begin
         pv[0] <= issue_vld;
         pa[0] <= ram_addr;
         pe[0] <= issue_exp;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pe[i] <= pe[i-1];
         end

         if (cmp_vld) begin
            x         <= ram_q;
            err_count <= err_next;
            if (mismatch && (err_count == 9'd0)) begin
               first_err_addr <= pa[READ_LATENCY-1];
               first_err_data <= ram_q;
            end
         end

         case (state)
            ST_STARTUP: begin
               if (su_cnt == SCW'(STARTUP_CYCLES - 1)) begin
                  state <= ST_IDLE;
                  ready <= 1'b1;
               end else begin
                  su_cnt <= su_cnt + SCW'(1);
               end
            end
            ST_IDLE: begin
               if (start) begin
                  ready          <= 1'b0;
                  base_addr      <= first_addr;
                  base_word      <= first_word;
                  run_cnt        <= cnt_in;
                  err_count      <= 9'd0;
                  first_err_addr <= 8'h00;
                  first_err_data <= 8'h00;
                  if (cnt_in == 9'd0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state     <= ST_READ;
                     busy      <= 1'b1;
                     pass      <= 1'b0;
                     ram_addr  <= first_addr;
                     ram_enb   <= 1'b0;
                     ram_oeb   <= 1'b0;
                     issue_vld <= 1'b1;
                     issue_exp <= first_word;
                     idx       <= 9'd1;
                  end
               end
            end
            ST_READ: begin
               if (idx == run_cnt) begin
                  state     <= ST_DRAIN;
                  ram_enb   <= 1'b1;
                  ram_oeb   <= 1'b1;
                  issue_vld <= 1'b0;
                  drain_cnt <= DCW'(1);
               end else begin
                  ram_addr  <= base_addr + idx[7:0];
                  issue_exp <= base_word + idx[7:0];
                  idx       <= idx + 9'd1;
               end
            end
            ST_DRAIN: begin
               // The final compare lands on this same edge, so pass uses err_next.
               if (drain_cnt == DCW'(READ_LATENCY)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == 9'd0);
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               ready <= 1'b1;
            end
            default: state <= ST_STARTUP;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_reader_checker.sv
// Bench for ram_reader_checker: SPRAM model, directed and random runs against a pattern-check model.
module tb_ram_reader_checker;
   localparam int L  = 1;
   localparam int SC = 100;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [7:0] first_addr, first_word;
   logic [8:0] count;
   logic [7:0] ram_q, ram_addr, ram_d;
   logic       ram_enb, ram_oeb, ram_web;
   logic       ready, busy, done, pass;
   logic [8:0] err_count;
   logic [7:0] first_err_addr, first_err_data, x;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] mem [256];
   logic [7:0] qpipe [L];
   logic [7:0] obs_q [$];
   int         done_cnt = 0;
   int         const_bad = 0;
   logic [7:0] mx = 8'h00;

   ram_reader_checker #(.STARTUP_CYCLES(SC), .READ_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .count(count),
      .first_word(first_word), .ram_q(ram_q), .ram_addr(ram_addr), .ram_d(ram_d),
      .ram_enb(ram_enb), .ram_oeb(ram_oeb), .ram_web(ram_web), .ready(ready), .busy(busy),
      .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
      .first_err_data(first_err_data), .x(x));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!ram_enb && !ram_oeb) qpipe[0] <= mem[ram_addr];
      for (int i = 1; i < L; i++) qpipe[i] <= qpipe[i-1];
   end
   assign ram_q = qpipe[L-1];

   always @(negedge clk) begin
      if (ram_enb === 1'b0) obs_q.push_back(ram_addr);
      if (done === 1'b1) done_cnt++;
      if (ram_web !== 1'b1 || ram_d !== 8'h00) const_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [7:0] fa, input int cnt_raw,
                      input logic [7:0] fw, input bit start_in_done);
      int n, errs, got, bad, k;
      logic [7:0] fea, fed, a;
      n = (cnt_raw > 256) ? 256 : cnt_raw;
      errs = 0; fea = 8'h00; fed = 8'h00;
      for (int i = 0; i < n; i++) begin
         a = 8'(fa + i);
         if (mem[a] != 8'(fw + i)) begin
            if (errs == 0) begin fea = a; fed = mem[a]; end
            errs++;
         end
      end
      if (n > 0) mx = mem[8'(fa + n - 1)];

      got = 0;
      for (int w = 0; w < 400 && got == 0; w++) begin
         @(negedge clk);
         if (ready === 1'b1) got = 1;
      end
      chk({tag, " ready"}, got, 1);

      first_addr = fa; count = 9'(cnt_raw); first_word = fw;
      obs_q.delete();
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      got = 0; k = 0;
      while (got == 0 && k < 700) begin
         @(negedge clk); k++;
         if (done === 1'b1) got = k;
      end
      chk({tag, " done_cycle"}, got, (n == 0) ? 1 : n + L + 1);
      chk({tag, " pass"}, pass, (errs == 0) ? 1 : 0);
      chk({tag, " err_count"}, err_count, errs);
      chk({tag, " first_err_addr"}, first_err_addr, fea);
      chk({tag, " first_err_data"}, first_err_data, fed);
      chk({tag, " x"}, x, mx);
      chk({tag, " busy_at_done"}, busy, 0);
      chk({tag, " addr_count"}, obs_q.size(), n);
      bad = 0;
      for (int i = 0; i < n && i < obs_q.size(); i++)
         if (obs_q[i] !== 8'(fa + i)) bad++;
      chk({tag, " addr_seq"}, bad, 0);

      if (start_in_done) begin
         start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         @(negedge clk);
         chk({tag, " ready_after_done"}, ready, 1);
         @(negedge clk);
         chk({tag, " start_in_done_ignored"}, busy, 0);
         chk({tag, " no_new_access"}, obs_q.size(), n);
      end
      repeat (2) @(negedge clk);
      chk({tag, " err_hold"}, err_count, errs);
      chk({tag, " done_once"}, done, 0);
   endtask

   task automatic fill(input logic [7:0] fa, input int n, input logic [7:0] fw);
      for (int i = 0; i < n; i++) mem[8'(fa + i)] = 8'(fw + i);
   endtask

   initial begin
      int got, dc, c, ne;
      logic [7:0] fa, fw;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
      for (int i = 0; i < L; i++) qpipe[i] = 8'h00;
      reset = 1'b1; start = 1'b0; first_addr = 8'h00; count = 9'd0; first_word = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst ram_addr", ram_addr, 0);
      chk("rst ram_enb", ram_enb, 1);
      chk("rst ram_oeb", ram_oeb, 1);
      chk("rst ready", ready, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst pass", pass, 0);
      chk("rst err_count", err_count, 0);
      chk("rst x", x, 0);

      // Startup window with start pulses that must be ignored
      reset = 1'b0;
      obs_q.delete();
      got = 0;
      for (int n = 1; n <= 300 && got == 0; n++) begin
         @(negedge clk);
         start = (n == 10 || n == 50) ? 1'b1 : 1'b0;
         if (ready === 1'b1) got = n;
      end
      start = 1'b0;
      chk("startup ready_cycle", got, SC);
      chk("startup no_access", obs_q.size(), 0);
      chk("startup busy", busy, 0);

      // Directed runs
      for (int i = 0; i < 9; i++) mem[i] = 8'(8'hA0 + i);
      run("basic", 8'h00, 9, 8'hA0, 1'b0);
      mem[5] = 8'h3C;
      run("err5", 8'h00, 9, 8'hA0, 1'b0);
      mem[8'hFE] = 8'h10; mem[8'hFF] = 8'h11; mem[8'h00] = 8'h12; mem[8'h01] = 8'h13;
      run("wrap", 8'hFE, 4, 8'h10, 1'b0);
      run("zero", 8'h40, 0, 8'h00, 1'b1);
      fill(8'h37, 256, 8'h5A);
      mem[8'h80] = ~mem[8'h80];
      mem[8'h20] = ~mem[8'h20];
      run("full256", 8'h37, 256, 8'h5A, 1'b0);
      fill(8'h00, 256, 8'hC3);
      run("clamp300", 8'h00, 300, 8'hC3, 1'b1);

      // Random runs
      for (int r = 0; r < 8; r++) begin
         fa = 8'($urandom); fw = 8'($urandom);
         c = (r == 3) ? 257 + $urandom_range(0, 254) : $urandom_range(1, 40);
         fill(fa, (c > 256) ? 256 : c, fw);
         if ($urandom_range(0, 1) == 1) begin
            ne = $urandom_range(1, 3);
            for (int e = 0; e < ne; e++)
               mem[8'(fa + $urandom_range(0, ((c > 256) ? 256 : c) - 1))] ^= 8'($urandom_range(1, 255));
         end
         run($sformatf("rand%0d", r), fa, c, fw, 1'b0);
      end

      // Reset during READ at index 3
      for (int i = 0; i < 9; i++) mem[i] = 8'(8'h20 + i);
      got = 0;
      for (int w = 0; w < 400 && got == 0; w++) begin
         @(negedge clk);
         if (ready === 1'b1) got = 1;
      end
      chk("midrst ready", got, 1);
      first_addr = 8'h00; count = 9'd9; first_word = 8'h20;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      got = 0;
      for (int w = 0; w < 20 && got == 0; w++) begin
         @(negedge clk);
         if (ram_enb === 1'b0 && ram_addr === 8'h03) got = 1;
      end
      chk("midrst reached_idx3", got, 1);
      dc = done_cnt;
      reset = 1'b1;
      @(negedge clk);
      chk("midrst ram_enb", ram_enb, 1);
      chk("midrst busy", busy, 0);
      chk("midrst done", done, 0);
      chk("midrst x", x, 0);
      chk("midrst ready", ready, 0);
      reset = 1'b0;
      obs_q.delete();
      got = 0;
      for (int n = 1; n <= 300 && got == 0; n++) begin
         @(negedge clk);
         if (ready === 1'b1) got = n;
      end
      chk("midrst restart_cycle", got, SC);
      chk("midrst no_done", done_cnt, dc);
      chk("midrst no_access", obs_q.size(), 0);
      chk("const ram_d_web", const_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_reader_checker.md
# ram_reader_checker

Downstream read-back stage for the SPRAM256X8 test path. After the writer stage has filled a region of the 256x8 single-port RAM with an incrementing byte pattern, this block takes over the RAM port, streams reads over a programmable address window, and compares each returned byte against the expected pattern. It reports pass/fail, the mismatch count and the first failing location, and exposes the last byte read for observation.

## Interface
Parameters:
- STARTUP_CYCLES, 100: clock cycles the RAM port is held idle after reset before any access.
- READ_LATENCY, 1: cycles from address/ENB/OEB presented at a clock edge to valid Q sampled (1..4).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a check run; sampled only in IDLE.
- first_addr  in  8  first RAM address to read.
- count  in  9  number of words to read, 0..256; values >256 treated as 256.
- first_word  in  8  expected data at first_addr; expected(i) = first_word + i mod 256.
- ram_q  in  8  RAM data output (SPRAM Q).
- ram_addr  out  8  RAM address (SPRAM ADR).
- ram_d  out  8  RAM data input; constant 8'h00.
- ram_enb  out  1  RAM enable, active-low.
- ram_oeb  out  1  RAM output enable, active-low.
- ram_web  out  1  RAM write enable, active-low; constant 1 (block never writes).
- ready  out  1  high in IDLE only.
- busy  out  1  high in READ and DRAIN.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  valid from done until next start: err_count == 0.
- err_count  out  9  mismatches in last run.
- first_err_addr  out  8  address of first mismatch (0 if none).
- first_err_data  out  8  byte read at first mismatch (0 if none).
- x  out  8  last compared byte from ram_q.

## Operation
- States: STARTUP, IDLE, READ, DRAIN, DONE.
- STARTUP: counter counts to STARTUP_CYCLES; then IDLE. start ignored.
- IDLE: ready=1. On start=1: latch first_addr, clamped count, first_word; clear err_count, first_err_*, pass; go READ (or DONE directly if count==0).
- READ: one address per cycle; ram_addr = first_addr + issue_idx (8-bit wrap, 8'hFF -> 8'h00); ram_enb=0, ram_oeb=0. After count issues go DRAIN.
- Compare pipeline: READ_LATENCY-deep shift register carrying {valid, addr, expected}. When a valid entry emerges, sample ram_q into x; if ram_q != expected, increment err_count and, if first mismatch, capture addr/data.
- DRAIN: ram_enb=1, ram_oeb=1; wait READ_LATENCY cycles for outstanding compares; then DONE.
- DONE: done=1 one cycle; pass = (err_count==0); go IDLE.
- Expected arithmetic 8-bit modulo; err_count saturates at 256 (cannot exceed count).

## Timing
- Reset values: state STARTUP, ram_addr=0, ram_d=0, ram_enb=1, ram_oeb=1, ram_web=1, ready=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, first_err_data=0, x=0.
- Reset mid-run: run aborted, no done, all outputs to reset values, STARTUP re-entered.
- start sampled at edge E in IDLE: first address on ram_addr from E+1; last address at E+count; done high in cycle E+count+READ_LATENCY+1.
- count==0: done pulse in cycle E+1, pass=1, no RAM access.
- count==256: every address read exactly once, wrapping through 8'hFF.
- start held high: only one run per IDLE entry; a start asserted in the DONE cycle is ignored.
- Results (pass, err_count, first_err_*, x) hold until next accepted start.

## Test plan
- Reset, RAM preloaded addr 0..8 = A0..A8; start with first_addr=0, count=9, first_word=A0 -> done at E+11 (READ_LATENCY=1), pass=1, err_count=0, x=A8.
- Same, but addr 5 preloaded 0x3C -> pass=0, err_count=1, first_err_addr=5, first_err_data=3C.
- Wrap: addr FE,FF,00,01 = 10..13; first_addr=FE, count=4, first_word=10 -> ram_addr sequence FE,FF,00,01; pass=1.
- start pulsed during STARTUP (cycles 0..99) -> ignored, ready rises at cycle 100, no RAM access before.
- count=0 -> done in cycle E+1, pass=1, ram_enb stays 1.
- reset asserted during READ at index 3 -> next cycle ram_enb=1, busy=0, done never pulses, STARTUP re-runs 100 cycles.
